// File: rtl/inst_fetch.sv
// inst_fetch: MIPS instruction-fetch stage; owns the PC, fetches over req/ready, drives IF/ID.
// Latency: one edge from memory completion to IF/ID; zero-wait memory gives one instruction/cycle.
// Backpressure: stall_i freezes IF/ID; a fetch completing under stall parks in a 1-entry skid.
// Build option: define DELAY_SLOT_EN to honour the MIPS branch delay slot on redirect.
// Ports: clk, rst (synchronous, active-high);
//        stall_i, redirect_i, redirect_pc_i from decode;
//        imem_req_o, imem_addr_o, imem_ready_i, imem_rdata_i to instruction memory;
//        inst_o, pc_o, pc4_o, valid_o form the IF/ID pipeline register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
`ifdef DELAY_SLOT_EN
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_q, pend_d;
`endif

  logic        done;
  logic        stall_eff;
  logic [31:0] tgt;

  // Request is suppressed while rst is high so it first rises the cycle after release.
  assign imem_req_o  = ~rst & ((state_q == S_FETCH) | (state_q == S_DISCARD));
  assign imem_addr_o = req_addr_q;
  assign done        = imem_req_o & imem_ready_i;
  // A redirect overrides a simultaneous stall.
  assign stall_eff   = stall_i & ~redirect_i;
  assign tgt         = redirect_pc_i & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    inst_d      = inst_q;
    ifid_pc_d   = ifid_pc_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
`ifdef DELAY_SLOT_EN
    pend_tgt_d  = pend_tgt_q;
    pend_d      = pend_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (done) begin
          if (stall_eff) begin
            skid_inst_d = imem_rdata_i;
            skid_pc_d   = req_addr_q;
            state_d     = S_HOLD;
          end else begin
            inst_d    = imem_rdata_i;
            ifid_pc_d = req_addr_q;
            pc4_d     = req_addr_q + 32'd4;
            valid_d   = 1'b1;
          end
          pc_d = pc_q + 32'd4;
`ifdef DELAY_SLOT_EN
          // The delay-slot fetch just completed; now take the deferred branch.
          if (pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end
`endif
        end else if (!stall_eff) begin
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall_eff) begin
          inst_d    = skid_inst_q;
          ifid_pc_d = skid_pc_q;
          pc4_d     = skid_pc_q + 32'd4;
          valid_d   = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (!stall_eff) valid_d = 1'b0;
        if (done) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (redirect_i) begin
`ifdef DELAY_SLOT_EN
      // Delay slot already in hand (completing now, or parked in the skid and
      // moving to IF/ID now): jump immediately. Otherwise defer until it arrives.
      if ((state_q == S_FETCH && done) || state_q == S_HOLD) begin
        pc_d   = tgt;
        pend_d = 1'b0;
      end else begin
        pend_tgt_d = tgt;
        pend_d     = 1'b1;
      end
`else
      valid_d     = 1'b0;
      skid_inst_d = 32'd0;
      skid_pc_d   = 32'd0;
      pc_d        = tgt;
      // An uncompleted request cannot be withdrawn; drain it in DISCARD.
      state_d     = (imem_req_o && !done) ? S_DISCARD : S_FETCH;
`endif
    end

    // Latch a new fetch address only when no request is in flight across this edge.
    if (state_d == S_FETCH && !(state_q == S_FETCH && imem_req_o && !done)) begin
      req_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC_AL;
      req_addr_q  <= RESET_PC_AL;
      skid_inst_q <= 32'd0;
      skid_pc_q   <= 32'd0;
      inst_q      <= 32'd0;
      ifid_pc_q   <= 32'd0;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
`ifdef DELAY_SLOT_EN
      pend_tgt_q  <= 32'd0;
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      inst_q      <= inst_d;
      ifid_pc_q   <= ifid_pc_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
`ifdef DELAY_SLOT_EN
      pend_tgt_q  <= pend_tgt_d;
      pend_q      <= pend_d;
`endif
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = ifid_pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule
